// File: rtl/sc_popcount_accum.sv
// Stochastic-to-binary back end: popcounts each parallel bitstream word and sums FRAME_LEN words.
// Build macro SC_POPCNT_PIPE_EN adds a popcount register stage ahead of the accumulator.
module sc_popcount_accum #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned ACC_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_count
);
    localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] count_q, count_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] pc, acc_pc, sum;
    logic                 acc_take, acc_vld, acc_fire;

    always_comb begin
        pc = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            pc = pc + ACC_WIDTH'(in_bits[i]);
        end
    end

    assign out_valid = (state_q == StHold);
    assign out_count = count_q;
    // The accumulator may advance whenever no result is left stranded in the output register.
    assign acc_take  = !out_valid || out_ready;

`ifdef SC_POPCNT_PIPE_EN
    logic [ACC_WIDTH-1:0] pc_q;
    logic                 pc_vld;

    assign in_ready = !pc_vld || acc_take;
    assign acc_vld  = pc_vld;
    assign acc_pc   = pc_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pc_vld <= 1'b0;
            pc_q   <= '0;
        end else if (in_valid && in_ready) begin
            pc_vld <= 1'b1;
            pc_q   <= pc;
        end else if (acc_take) begin
            pc_vld <= 1'b0;
        end
    end
`else
    assign in_ready = acc_take;
    assign acc_vld  = in_valid;
    assign acc_pc   = pc;
`endif

    assign acc_fire = acc_vld && acc_take && !clr;
    assign sum      = acc_q + acc_pc;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        count_d = count_q;

        case (state_q)
            StHold:  if (out_ready) state_d = StAccum;
            default: state_d = state_q;
        endcase

        // clr drops only the partial frame; a held result survives until taken.
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (acc_fire) begin
            if (cnt_q == LastCnt) begin
                count_d = sum;
                state_d = StHold;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

endmodule
